// File: rtl/add_operand_sequencer.sv
// Operand FIFO feeding an external combinational adder, with a single-entry
// registered result stage and a valid/ready handshake on both sides.
module add_operand_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH-1:0]           add_o,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Operand storage is read combinationally so the head pair reaches the
    // adder in the same cycle it becomes the head.
    logic [WIDTH-1:0] a_mem [DEPTH];
    logic [WIDTH-1:0] b_mem [DEPTH];

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] out_sum_reg, out_sum_next;

    logic             push;
    logic             pop;
    logic             out_free;
    logic             fifo_empty;
    logic [DEPTH-1:0] wr_en;

    assign fifo_empty = (count_reg == '0);
    assign in_ready   = (count_reg < DEPTH_C);
    assign out_free   = !out_valid_reg || out_ready;
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty && out_free;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                a_mem[i] <= in_a;
                b_mem[i] <= in_b;
            end
        end
    end

    // Idle adder inputs are forced to zero so stale entries never toggle it.
    assign add_a = fifo_empty ? '0 : a_mem[rd_ptr_reg];
    assign add_b = fifo_empty ? '0 : b_mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        out_valid_next = out_valid_reg;
        out_sum_next   = out_sum_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end

        if (pop) begin
            rd_ptr_next    = rd_ptr_reg + PW'(1);
            out_sum_next   = add_o;
            out_valid_next = 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        unique case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            out_valid_reg <= out_valid_next;
            out_sum_reg   <= out_sum_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_add_operand_sequencer.sv
// Directed bench for add_operand_sequencer; the external adder is modelled
// as a plain combinational sum, expectations are hand-computed constants.
module tb_add_operand_sequencer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [WIDTH-1:0]  add_a;
    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  add_o;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sum;
    logic [$clog2(DEPTH):0] count;

    int checks_total  = 0;
    int checks_passed = 0;

    add_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_o     (add_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .count     (count)
    );

    always #5 clk = ~clk;

    assign add_o = add_a + add_b;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            $display("xfer: out_sum=0x%04h", out_sum);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            checks_passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset state
        step();
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_add_a", 32'(add_a), 0);
        check("rst_add_b", 32'(add_b), 0);
        rst_n = 1'b1;
        step();

        // Single operation: two-edge latency
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0FED;
        step();
        in_valid = 1'b0;
        check("single_count_after_push", 32'(count), 1);
        check("single_add_a", 32'(add_a), 32'h1234);
        check("single_add_b", 32'(add_b), 32'h0FED);
        check("single_not_yet_valid", 32'(out_valid), 0);
        step();
        check("single_valid", 32'(out_valid), 1);
        check("single_sum", 32'(out_sum), 32'h2221);
        check("single_count_back", 32'(count), 0);
        check("single_idle_add_a", 32'(add_a), 0);
        step();
        check("single_valid_clears", 32'(out_valid), 0);

        // Modulo-2^WIDTH wrap
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001;
        step();
        in_a = 16'h8000; in_b = 16'h8000;
        step();
        in_valid = 1'b0;
        check("wrap1_valid", 32'(out_valid), 1);
        check("wrap1_sum", 32'(out_sum), 0);
        check("wrap1_count", 32'(count), 1);
        check("wrap2_add_a", 32'(add_a), 32'h8000);
        step();
        check("wrap2_valid", 32'(out_valid), 1);
        check("wrap2_sum", 32'(out_sum), 0);
        check("wrap2_count", 32'(count), 0);
        step();
        check("wrap_valid_clears", 32'(out_valid), 0);

        // Full FIFO with output backpressure
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("bp_in_ready_before_push", 32'(in_ready), 1);
            in_valid = 1'b1; in_a = 16'(k); in_b = 16'(k);
            step();
        end
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_out_sum_held", 32'(out_sum), 2);
        check("bp_count_full", 32'(count), 4);
        check("bp_in_ready_full", 32'(in_ready), 0);
        in_a = 16'd9; in_b = 16'd9;
        step();
        in_valid = 1'b0;
        check("bp_no_push_when_full", 32'(count), 4);
        check("bp_sum_stable", 32'(out_sum), 2);
        check("bp_valid_stable", 32'(out_valid), 1);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            check("bp_drain_valid", 32'(out_valid), 1);
            check("bp_drain_sum", 32'(out_sum), 32'(2 * k));
            check("bp_drain_count", 32'(count), 32'(5 - k));
        end
        step();
        check("bp_drain_done", 32'(out_valid), 0);
        check("bp_drain_in_ready", 32'(in_ready), 1);

        // Streaming one result per cycle
        in_valid = 1'b1; in_a = 16'd0; in_b = 16'd0;
        for (int j = 0; j <= 20; j++) begin
            step();
            check("stream_count_le1", 32'(count <= 1), 1);
            if (j >= 1) begin
                check("stream_valid", 32'(out_valid), 1);
                check("stream_sum", 32'(out_sum), 32'(4 * (j - 1)));
            end
            if (j + 1 < 20) begin
                in_a = 16'(j + 1); in_b = 16'(3 * (j + 1));
            end else begin
                in_valid = 1'b0;
            end
        end
        check("stream_count_end", 32'(count), 0);
        step();
        check("stream_valid_end", 32'(out_valid), 0);

        // Reset in the middle of a run
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_a = 16'(16 * k); in_b = 16'(k);
            step();
        end
        in_valid = 1'b0;
        check("mid_pre_count", 32'(count), 3);
        check("mid_pre_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(out_valid), 0);
        check("mid_async_count", 32'(count), 0);
        check("mid_async_in_ready", 32'(in_ready), 1);
        check("mid_async_add_a", 32'(add_a), 0);
        check("mid_async_out_sum", 32'(out_sum), 0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("mid_no_stale_valid", 32'(out_valid), 0);
            check("mid_no_stale_count", 32'(count), 0);
        end

        // Resume after reset
        in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0023;
        step();
        in_valid = 1'b0;
        step();
        check("resume_valid", 32'(out_valid), 1);
        check("resume_sum", 32'(out_sum), 32'h0123);

        // Empty idle
        for (int k = 0; k < 10; k++) begin
            step();
            if (k >= 1) begin
                check("idle_add_a", 32'(add_a), 0);
                check("idle_add_b", 32'(add_b), 0);
                check("idle_valid", 32'(out_valid), 0);
                check("idle_count", 32'(count), 0);
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/add_operand_sequencer.md
ADD_OPERAND_SEQUENCER -- requirements
Module: add_operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, operand FIFO entries; legal values: power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a pair.
REQ-007 SHALL have port in_a  input  WIDTH  operand A.
REQ-008 SHALL have port in_b  input  WIDTH  operand B.
REQ-009 SHALL have port add_a  output  WIDTH  operand A driven to the downstream combinational adder.
REQ-010 SHALL have port add_b  output  WIDTH  operand B driven to the downstream combinational adder.
REQ-011 SHALL have port add_o  input  WIDTH  sum returned by the combinational adder, settled within the same cycle.
REQ-012 SHALL have port out_valid  output  1  out_sum holds a result.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port out_sum  output  WIDTH  registered sum.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL accept a pair (push) at a rising edge where in_valid=1 and in_ready=1; no other edge writes the FIFO.
REQ-017 SHALL drive in_ready = (count < DEPTH) from registered state only; no combinational path from out_ready or in_valid.
REQ-018 SHALL drive add_a/add_b from the FIFO head entry when count>0, and 0/0 when count=0.
REQ-019 SHALL have a one-entry output register; it is "free" when out_valid=0 or out_ready=1.
REQ-020 SHALL capture (pop) at a rising edge where count>0 and the output register is free: out_sum <= add_o, out_valid <= 1, head pointer advances.
REQ-021 SHALL clear out_valid at an edge where out_valid=1, out_ready=1 and no capture occurs.
REQ-022 SHALL hold out_sum and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL give latency: pair pushed at edge t into an empty FIFO with a free output register -> out_valid=1 with its sum after edge t+1.
REQ-024 SHALL sustain one result per cycle when in_valid and out_ready are held high.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged; push only -> count+1; pop only -> count-1.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; results emerge in exact push order.
REQ-027 SHALL treat sums as modulo 2^WIDTH; no carry out, no overflow indication (adder provides none).
REQ-028 SHALL not pop when count=0; out_valid then clears per REQ-021 or holds per REQ-022.
REQ-029 SHALL drive count from registered state and never exceed DEPTH or underflow below 0.

Reset
REQ-030 SHALL, on rst_n=0, immediately and asynchronously set count=0, pointers=0, out_valid=0, out_sum=0; in_ready=1 and add_a=add_b=0 follow.
REQ-031 SHALL, on reset mid-operation, discard all queued pairs and any pending result; none appear after release.
REQ-032 SHALL resume normal operation at the first rising edge after rst_n returns high.

Verification
REQ-033 SHALL pass single op: push a=0x1234,b=0x0FED at edge t -> out_valid=1, out_sum=0x2221 after edge t+1, count back to 0.
REQ-034 SHALL pass wrap: push a=0xFFFF,b=0x0001 -> out_sum=0x0000; push 0x8000+0x8000 -> 0x0000.
REQ-035 SHALL pass full/backpressure: out_ready=0, push 5 pairs (1+1..5+5) -> sum 2 in out register, count=4, in_ready=0; release out_ready -> 2,4,6,8,10 in order.
REQ-036 SHALL pass streaming: in_valid=out_ready=1 for 20 cycles, a=i,b=3i -> 20 results 4i back-to-back, count<=1 throughout.
REQ-037 SHALL pass reset mid-run: 3 pairs queued, out_valid=1, assert rst_n=0 between edges -> out_valid=0, count=0, in_ready=1 immediately; no stale result after release.
REQ-038 SHALL pass empty idle: no pushes for 10 cycles -> add_a=add_b=0, out_valid=0, count=0.
